ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 8-bit pipelined processor. Sits between decode and the data-memory stage.
- Selects forwarded operands, computes the ALU result and flags, and registers the result and memory controls into the EX/MEM boundary.
- Its registered outputs ans_ex, DM_data, mem_rw_ex and mem_en_ex drive the data-memory stage directly.
- Contains an iterative 8-cycle multiplier that stalls upstream while it runs.

Parameters:
- MUL_CYCLES, 8, shift-add iterations per multiply; must equal the data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- A  in  8  operand A from decode register read.
- B  in  8  operand B / store data from decode register read.
- imm  in  8  immediate from decode.
- imm_sel  in  1  1 = ALU operand B is imm; store data is still forwarded B.
- alu_op  in  4  operation code (see package).
- valid_id  in  1  decode holds a real instruction.
- mem_rw_id, mem_en_id, mem_mux_sel_id  in  1 each  memory controls from decode.
- fwd_a_sel, fwd_b_sel  in  2 each  forwarding select: 00 register value, 01 ans_ex, 10 ans_dm, 11 ans_wb.
- ans_dm  in  8  forwarded result of the data-memory stage.
- ans_wb  in  8  forwarded writeback value.
- flush  in  1  kill the instruction in EX.
- ans_ex  out  8  registered ALU result / memory address.
- DM_data  out  8  registered store data (forwarded B).
- mem_rw_ex, mem_en_ex, mem_mux_sel_ex  out  1 each  registered memory controls.
- valid_ex  out  1  registered instruction-valid flag.
- flags  out  4  registered {Z,N,C,V}.
- stall  out  1  combinational; decode must hold its inputs while high.

Behaviour:
- Reset (asynchronous, reset=0):
  - All registered outputs clear to 0; flags clear to 0.
  - FSM goes to IDLE and the iteration counter clears to 0.
  - stall is 0 while reset is asserted.
- Non-MUL ops, 1-cycle latency:
  - Inputs sampled at a rising edge appear on the outputs after that edge.
  - Control outputs copy the *_id controls gated by valid_id.
- Bubble: when valid_id=0, outputs load valid_ex=0, mem_en_ex=0 and mem_rw_ex=0; ans_ex and DM_data take don't-care values.
- Operations, 8-bit, wrap-around:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL1 A, 7 SHR1 A (logical), 8 PASS Bop, 9 MUL (low byte).
  - Codes 10-15 give result 0 and leave flags unchanged.
- Flags update only on a valid instruction with a defined op:
  - Z = (result==0); N = result[7].
  - C: ADD carry-out; SUB borrow (A<Bop unsigned); SHL A[7]; SHR A[0]; MUL high byte !=0; logic ops and PASS give 0.
  - V: signed overflow for ADD/SUB, otherwise 0.
- Forwarding select 01 uses the current ans_ex register (EX->EX back-to-back).
- MUL FSM, states IDLE and BUSY:
  - IDLE with valid_id, alu_op=9 and no flush: latch forwarded operands and controls, assert stall, load a bubble into the outputs, go to BUSY with cnt=0.
  - BUSY: one shift-add step per cycle. stall = (cnt != MUL_CYCLES-1).
  - At cnt = MUL_CYCLES-1: outputs load the product low byte, the latched controls, valid_ex=1 and the flags; FSM returns to IDLE.
  - Totals: stall is high for exactly 8 cycles; the result appears 9 edges after first presentation.
  - decode inputs are ignored during BUSY.
- Flush: the next edge loads a bubble. In BUSY it aborts to IDLE with stall=0 the same cycle and flags unchanged. Flush overrides stall and MUL start.
- Reset mid-multiply: immediate abort, all outputs 0.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: MUL FSM, multiplier and stall logic are present as described.
- Undefined: FSM and multiplier are removed, stall is tied 0, and alu_op=9 behaves like codes 10-15 (result 0, flags unchanged, 1-cycle latency).

Decomposition:
- Package ex_pkg holds:
  - opcode localparams ALU_ADD..ALU_MUL;
  - forward-select encodings FWD_REG/FWD_EX/FWD_DM/FWD_WB;
  - FSM state encoding;
  - flag bit indices Z=3, N=2, C=1, V=0.
- One sub-module, ex_mul_seq: iterative shift-add multiplier with start/abort/done and 16-bit product. Instantiated only under EX_MUL_EN.

Test Plan:
- ADD, A=0x7F, Bop=0x01 -> after one edge ans_ex=0x80, flags Z0 N1 C0 V1, valid_ex=1.
- SUB, A=B=0x05 -> ans_ex=0x00, Z1 C0; then ADD with imm_sel=1, A=0x10, imm=0x04, B=0xAA, mem_en_id=mem_rw_id=1 -> ans_ex=0x14, DM_data=0xAA, mem_en_ex=mem_rw_ex=1.
- Forwarding: fwd_a_sel=10, ans_dm=0x33, imm=0x01 ADD -> 0x34; back-to-back with fwd_a_sel=01 -> 0x35.
- MUL 0x0F*0x11 -> stall high exactly 8 cycles, ans_ex=0xFF with C0 on the 9th edge; MUL 0x20*0x10 -> ans_ex=0x00, Z1 C1.
- flush during BUSY cnt=3 -> stall drops the same cycle, next edge valid_ex=0, FSM IDLE; the following ADD completes in 1 cycle.
- reset=0 asserted mid-MUL between clock edges -> all outputs 0 immediately; after release a MUL restarts cleanly.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: opcodes, forward selects, FSM encoding, flag indices and the ALU helper shared by ex_stage.
package ex_pkg;
    localparam int MUL_CYCLES = 8;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOT  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_PASS = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_DM  = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       def;
    } alu_out_t;
    // Single-cycle ops only; MUL and unused codes report def=0 with a zero result.
    function automatic alu_out_t alu_eval(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        alu_out_t r;
        r = '0;
        r.def = 1'b1;
        s = '0;
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r.res = s[7:0];
                r.c = s[8];
                r.v = (a[7] == b[7]) && (s[7] != a[7]);
            end
            ALU_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                r.res = s[7:0];
                r.c = s[8];
                r.v = (a[7] != b[7]) && (s[7] != a[7]);
            end
            ALU_AND:  r.res = a & b;
            ALU_OR:   r.res = a | b;
            ALU_XOR:  r.res = a ^ b;
            ALU_NOT:  r.res = ~a;
            ALU_SHL:  begin r.res = {a[6:0], 1'b0}; r.c = a[7]; end
            ALU_SHR:  begin r.res = {1'b0, a[7:1]}; r.c = a[0]; end
            ALU_PASS: r.res = b;
            default:  r.def = 1'b0;
        endcase
        return r;
    endfunction
    function automatic logic [3:0] flag_pack(input logic [7:0] r, input logic c, input logic v);
        logic [3:0] f;
        f = '0;
        f[FLAG_Z] = (r == 8'h00);
        f[FLAG_N] = r[7];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction
endpackage

// File: rtl/ex_stage_mul.sv
// ex_mul_seq: iterative shift-add multiplier; one partial product per cycle while run is high.
module ex_mul_seq
    import ex_pkg::*;
#(
    parameter int W = MUL_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           run,
    input  logic           abort,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           done
);
    localparam int CW = $clog2(W);
    logic [2*W-1:0] mcand, acc;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    // product already includes the current step, so the last step needs no extra edge
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done = run & (cnt == CW'(W - 1));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand <= '0;
            acc <= '0;
            mplier <= '0;
            cnt <= '0;
        end else if (start) begin
            mcand <= {{W{1'b0}}, a};
            acc <= '0;
            mplier <= b;
            cnt <= '0;
        end else if (abort | done) begin
            cnt <= '0;
        end else if (run) begin
            acc <= product;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, ALU/flags and the EX/MEM register.
// Defining EX_MUL_EN adds the iterative multiplier and the stall it raises while busy.
module ex_stage
    import ex_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [7:0] imm,
    input  logic       imm_sel,
    input  logic [3:0] alu_op,
    input  logic       valid_id,
    input  logic       mem_rw_id,
    input  logic       mem_en_id,
    input  logic       mem_mux_sel_id,
    input  logic [1:0] fwd_a_sel,
    input  logic [1:0] fwd_b_sel,
    input  logic [7:0] ans_dm,
    input  logic [7:0] ans_wb,
    input  logic       flush,
    output logic [7:0] ans_ex,
    output logic [7:0] DM_data,
    output logic       mem_rw_ex,
    output logic       mem_en_ex,
    output logic       mem_mux_sel_ex,
    output logic       valid_ex,
    output logic [3:0] flags,
    output logic       stall
);
    logic [7:0]  a_op, b_fwd, b_op, dm_q;
    logic [15:0] prod;
    logic [2:0]  ctl_q;
    logic        live, go, mul_start, mul_done, busy;
    alu_out_t    alu;
    function automatic logic [7:0] fwd(input logic [1:0] sel, input logic [7:0] rv, input logic [7:0] ex,
                                       input logic [7:0] dm, input logic [7:0] wb);
        return sel == FWD_EX ? ex : sel == FWD_DM ? dm : sel == FWD_WB ? wb : rv;
    endfunction
    assign a_op  = fwd(fwd_a_sel, A, ans_ex, ans_dm, ans_wb);
    assign b_fwd = fwd(fwd_b_sel, B, ans_ex, ans_dm, ans_wb);
    assign b_op  = imm_sel ? imm : b_fwd;
    assign alu   = alu_eval(alu_op, a_op, b_op);
    assign live  = valid_id & ~flush;
    assign go    = live & ~mul_start;
`ifdef EX_MUL_EN
    logic [0:0] state;
    assign busy = state == ST_BUSY;
    assign mul_start = ~busy & live & (alu_op == ALU_MUL);
    assign stall = (mul_start | (busy & ~mul_done)) & ~flush & reset;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            dm_q <= '0;
            ctl_q <= '0;
        end else if (mul_start) begin
            state <= ST_BUSY;
            dm_q <= b_fwd;
            ctl_q <= {mem_rw_id, mem_en_id, mem_mux_sel_id};
        end else if (flush | mul_done) begin
            state <= ST_IDLE;
        end
    end
    ex_mul_seq #(.W(MUL_CYCLES)) u_mul (
        .clk(clk),
        .reset(reset),
        .start(mul_start),
        .run(busy),
        .abort(busy & flush),
        .a(a_op),
        .b(b_op),
        .product(prod),
        .done(mul_done)
    );
`else
    assign busy = 1'b0;
    assign mul_start = 1'b0;
    assign mul_done = 1'b0;
    assign stall = 1'b0;
    assign prod = '0;
    assign dm_q = '0;
    assign ctl_q = '0;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ans_ex <= '0;
            DM_data <= '0;
            mem_rw_ex <= 1'b0;
            mem_en_ex <= 1'b0;
            mem_mux_sel_ex <= 1'b0;
            valid_ex <= 1'b0;
            flags <= '0;
        end else if (busy & ~flush) begin
            if (mul_done) begin
                ans_ex <= prod[7:0];
                DM_data <= dm_q;
                {mem_rw_ex, mem_en_ex, mem_mux_sel_ex} <= ctl_q;
                valid_ex <= 1'b1;
                flags <= flag_pack(prod[7:0], |prod[15:8], 1'b0);
            end
        end else begin
            ans_ex <= alu.res;
            DM_data <= b_fwd;
            valid_ex <= go;
            mem_rw_ex <= mem_rw_id & go;
            mem_en_ex <= mem_en_id & go;
            mem_mux_sel_ex <= mem_mux_sel_id & go;
            if (live & alu.def)
                flags <= flag_pack(alu.res, alu.c, alu.v);
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table vectors, multi-cycle MUL/flush/reset sequences and a randomized model comparison.
module tb_ex_stage;
    import ex_pkg::*;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] A, B, imm, ans_dm, ans_wb, ans_ex, DM_data;
    logic       imm_sel, valid_id, mem_rw_id, mem_en_id, mem_mux_sel_id, flush;
    logic [3:0] alu_op, flags;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       mem_rw_ex, mem_en_ex, mem_mux_sel_ex, valid_ex, stall;
    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .imm(imm), .imm_sel(imm_sel), .alu_op(alu_op),
        .valid_id(valid_id), .mem_rw_id(mem_rw_id), .mem_en_id(mem_en_id), .mem_mux_sel_id(mem_mux_sel_id),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ans_dm(ans_dm), .ans_wb(ans_wb), .flush(flush),
        .ans_ex(ans_ex), .DM_data(DM_data), .mem_rw_ex(mem_rw_ex), .mem_en_ex(mem_en_ex),
        .mem_mux_sel_ex(mem_mux_sel_ex), .valid_ex(valid_ex), .flags(flags), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a, b, im;
        logic       isel;
        logic [1:0] fa, fb;
        logic [7:0] dm, wb;
        logic       v, fl, en, rw;
        logic [7:0] e_ans, e_dm;
        logic [3:0] e_fl;
    } vec_t;
    vec_t tbl [21];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] im,
                         input logic is, input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] dm,
                         input logic [7:0] wb, input logic v, input logic fl, input logic en, input logic rw);
        alu_op = op; A = a; B = b; imm = im; imm_sel = is; fwd_a_sel = fa; fwd_b_sel = fb;
        ans_dm = dm; ans_wb = wb; valid_id = v; flush = fl; mem_en_id = en; mem_rw_id = rw; mem_mux_sel_id = en;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ans"}, ans_ex, 8'h00);
        check({tag, "_dm"}, DM_data, 8'h00);
        check({tag, "_ctl"}, {5'b0, mem_rw_ex, mem_en_ex, mem_mux_sel_ex}, 8'h00);
        check({tag, "_valid"}, {7'b0, valid_ex}, 8'h00);
        check({tag, "_flags"}, {4'b0, flags}, 8'h00);
        check({tag, "_stall"}, {7'b0, stall}, 8'h00);
    endtask

    // Reference: plain integer arithmetic over the opcode rules, flags as {Z,N,C,V}.
    function automatic void model(input int op, input int x, input int y, output int res,
                                  output logic [3:0] fl, output bit def);
        int r, sx, sy;
        bit c, v;
        sx = x > 127 ? x - 256 : x;
        sy = y > 127 ? y - 256 : y;
        r = 0; c = 0; v = 0; def = 1;
        case (op)
            0: begin r = x + y; c = r > 255; v = (sx + sy > 127) || (sx + sy < -128); end
            1: begin r = x - y; c = x < y; v = (sx - sy > 127) || (sx - sy < -128); end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = 255 - x;
            6: begin r = x * 2; c = x > 127; end
            7: begin r = x / 2; c = (x % 2) == 1; end
            8: r = y;
`ifdef EX_MUL_EN
            9: begin r = x * y; c = r > 255; end
`endif
            default: def = 0;
        endcase
        res = r & 255;
        fl = {res == 0, res > 127, c, v};
    endfunction

`ifdef EX_MUL_EN
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e_lo, input logic [3:0] e_fl);
        int edges, nst;
        drive(ALU_MUL, a, b, 8'h00, 1'b0, FWD_REG, FWD_REG, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        edges = 0;
        nst = 0;
        do begin
            if (stall) nst++;
            else if (edges > 0) valid_id = 1'b0;
            tick;
            edges++;
            if (edges == 1) check("mul_bubble_valid", {7'b0, valid_ex}, 8'h00);
        end while (valid_ex !== 1'b1 && edges < 20);
        valid_id = 1'b0;
        check("mul_latency", 8'(edges), 8'd9);
        check("mul_stall_cycles", 8'(nst), 8'd8);
        check("mul_ans", ans_ex, e_lo);
        check("mul_flags", {4'b0, flags}, {4'b0, e_fl});
        check("mul_dm", DM_data, b);
        check("mul_en_rw", {6'b0, mem_en_ex, mem_rw_ex}, 8'b10);
    endtask
`endif

    int res, xa, xb, yb, op_r, exp_ans;
    logic [3:0] nf, exp_fl;
    bit def, known, live;
    logic [7:0] ra, rb, rim, rdm, rwb;
    logic [1:0] rfa, rfb;
    logic rv, rfl, ren, rrw, ris;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{ALU_ADD,  8'h7F, 8'h01, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h01, 4'b0101};
        tbl[1]  = '{ALU_SUB,  8'h05, 8'h05, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05, 4'b1000};
        tbl[2]  = '{ALU_ADD,  8'h10, 8'hAA, 8'h04, 1'b1, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h14, 8'hAA, 4'b0000};
        tbl[3]  = '{ALU_ADD,  8'h00, 8'h00, 8'h01, 1'b1, 2'd2, 2'd0, 8'h33, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h34, 8'h00, 4'b0000};
        tbl[4]  = '{ALU_ADD,  8'h00, 8'h00, 8'h01, 1'b1, 2'd1, 2'd0, 8'h33, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h35, 8'h00, 4'b0000};
        tbl[5]  = '{ALU_SUB,  8'h00, 8'h01, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h01, 4'b0110};
        tbl[6]  = '{ALU_SHL,  8'h81, 8'h00, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 4'b0010};
        tbl[7]  = '{ALU_SHR,  8'h01, 8'h00, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'b1010};
        tbl[8]  = '{4'd12,    8'h05, 8'h00, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'b1010};
        tbl[9]  = '{ALU_ADD,  8'h01, 8'h01, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 4'b1010};
        tbl[10] = '{ALU_SUB,  8'h80, 8'h01, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h01, 4'b0001};
        tbl[11] = '{ALU_AND,  8'hF0, 8'h00, 8'h00, 1'b0, 2'd0, 2'd3, 8'h00, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h0F, 4'b1000};
        tbl[12] = '{ALU_NOT,  8'h0F, 8'h00, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h00, 4'b0100};
        tbl[13] = '{ALU_PASS, 8'h00, 8'h11, 8'h80, 1'b1, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h11, 4'b0100};
        tbl[14] = '{ALU_XOR,  8'hFF, 8'hFF, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 4'b1000};
        tbl[15] = '{ALU_OR,   8'h0F, 8'hF0, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hF0, 4'b0100};
        tbl[16] = '{ALU_ADD,  8'h01, 8'h01, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 4'b0100};
        tbl[17] = '{ALU_ADD,  8'hFF, 8'h01, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 4'b1010};
        tbl[18] = '{ALU_ADD,  8'h80, 8'h80, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 4'b1011};
        tbl[19] = '{ALU_SUB,  8'h10, 8'h00, 8'h00, 1'b0, 2'd0, 2'd2, 8'h44, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCC, 8'h44, 4'b0110};
        tbl[20] = '{ALU_PASS, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCC, 8'hCC, 4'b0100};

        reset = 1'b0;
        drive(ALU_ADD, 8'h00, 8'h00, 8'h00, 1'b0, FWD_REG, FWD_REG, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        check_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            live = tbl[i].v & ~tbl[i].fl;
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].im, tbl[i].isel, tbl[i].fa, tbl[i].fb,
                  tbl[i].dm, tbl[i].wb, tbl[i].v, tbl[i].fl, tbl[i].en, tbl[i].rw);
            #1;
            check($sformatf("v%0d_stall", i), {7'b0, stall}, 8'h00);
            tick;
            check($sformatf("v%0d_valid", i), {7'b0, valid_ex}, {7'b0, live});
            check($sformatf("v%0d_ctl", i), {5'b0, mem_rw_ex, mem_en_ex, mem_mux_sel_ex},
                  {5'b0, tbl[i].rw & live, tbl[i].en & live, tbl[i].en & live});
            check($sformatf("v%0d_flags", i), {4'b0, flags}, {4'b0, tbl[i].e_fl});
            if (live) begin
                check($sformatf("v%0d_ans", i), ans_ex, tbl[i].e_ans);
                check($sformatf("v%0d_dm", i), DM_data, tbl[i].e_dm);
            end
        end

`ifdef EX_MUL_EN
        run_mul(8'h0F, 8'h11, 8'hFF, 4'b0100);
        run_mul(8'h20, 8'h10, 8'h00, 4'b1010);
        drive(ALU_MUL, 8'h0F, 8'h11, 8'h00, 1'b0, FWD_REG, FWD_REG, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) tick;
        check("busy_stall", {7'b0, stall}, 8'h01);
        flush = 1'b1;
        #1;
        check("flush_stall_drop", {7'b0, stall}, 8'h00);
        tick;
        check("flush_valid", {7'b0, valid_ex}, 8'h00);
        check("flush_en", {7'b0, mem_en_ex}, 8'h00);
        check("flush_flags", {4'b0, flags}, 8'h0A);
        drive(ALU_ADD, 8'h01, 8'h02, 8'h00, 1'b0, FWD_REG, FWD_REG, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("post_flush_stall", {7'b0, stall}, 8'h00);
        tick;
        check("post_flush_ans", ans_ex, 8'h03);
        check("post_flush_valid", {7'b0, valid_ex}, 8'h01);
        check("post_flush_flags", {4'b0, flags}, 8'h00);
        drive(ALU_SUB, 8'h00, 8'h01, 8'h00, 1'b0, FWD_REG, FWD_REG, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        check("pre_rst_ans", ans_ex, 8'hFF);
        drive(ALU_MUL, 8'h0F, 8'h11, 8'h00, 1'b0, FWD_REG, FWD_REG, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        tick;
        tick;
        check("pre_rst_stall", {7'b0, stall}, 8'h01);
        check("pre_rst_flags", {4'b0, flags}, 8'h06);
        #3 reset = 1'b0;
        #1 check_zero("mid_mul_reset");
        #1 reset = 1'b1;
        run_mul(8'h03, 8'h05, 8'h0F, 4'b0000);
`else
        drive(ALU_SUB, 8'h00, 8'h01, 8'h00, 1'b0, FWD_REG, FWD_REG, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        check("pre_mul_ans", ans_ex, 8'hFF);
        drive(ALU_MUL, 8'h03, 8'h05, 8'h00, 1'b0, FWD_REG, FWD_REG, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("nomul_stall", {7'b0, stall}, 8'h00);
        tick;
        check("nomul_ans", ans_ex, 8'h00);
        check("nomul_flags", {4'b0, flags}, 8'h06);
        check("nomul_valid", {7'b0, valid_ex}, 8'h01);
        #3 reset = 1'b0;
        #1 check_zero("async_reset");
        #1 reset = 1'b1;
`endif

        reset = 1'b0;
        #2 reset = 1'b1;
        exp_ans = 0;
        exp_fl = 4'b0000;
        known = 1;
        for (int i = 0; i < 300; i++) begin
            op_r = $urandom_range(0, 15);
`ifdef EX_MUL_EN
            if (op_r == 9) op_r = 8;
`endif
            ra = 8'($urandom); rb = 8'($urandom); rim = 8'($urandom); rdm = 8'($urandom); rwb = 8'($urandom);
            rfa = 2'($urandom); rfb = 2'($urandom); ris = 1'($urandom);
            if (!known && rfa == FWD_EX) rfa = FWD_REG;
            if (!known && rfb == FWD_EX) rfb = FWD_REG;
            rv = $urandom_range(0, 9) != 0;
            rfl = $urandom_range(0, 15) == 0;
            ren = 1'($urandom); rrw = 1'($urandom);
            xa = rfa == 2'd0 ? int'(ra) : rfa == 2'd1 ? exp_ans : rfa == 2'd2 ? int'(rdm) : int'(rwb);
            xb = rfb == 2'd0 ? int'(rb) : rfb == 2'd1 ? exp_ans : rfb == 2'd2 ? int'(rdm) : int'(rwb);
            yb = ris ? int'(rim) : xb;
            model(op_r, xa, yb, res, nf, def);
            live = rv & ~rfl;
            drive(4'(op_r), ra, rb, rim, ris, rfa, rfb, rdm, rwb, rv, rfl, ren, rrw);
            tick;
            if (live && def) exp_fl = nf;
            check("rnd_valid", {7'b0, valid_ex}, {7'b0, live});
            check("rnd_ctl", {5'b0, mem_rw_ex, mem_en_ex, mem_mux_sel_ex}, {5'b0, rrw & live, ren & live, ren & live});
            check("rnd_flags", {4'b0, flags}, {4'b0, exp_fl});
            if (live) begin
                check("rnd_ans", ans_ex, 8'(res));
                check("rnd_dm", DM_data, 8'(xb));
            end
            exp_ans = res;
            known = live;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
